pmem_responder: RTL and testbench
=================================

# pmem_responder

Line-granular physical-memory responder for the L2/eviction-write-buffer memory side. It accepts the 256-bit `pmem_read`/`pmem_write` request issued by the write-back path and answers with a one-cycle `pmem_resp` after a fixed, parameterised latency. It is backed by a small on-chip line array. It is the synthesizable stand-in for main memory in the top-level processor build and in cache/EWB benches.

## Interface
- `DEPTH`, 16: number of 256-bit lines; power of two, ≥2; `IDX_W = $clog2(DEPTH)`.
- `LATENCY`, 4: cycles from request acceptance to `pmem_resp`; ≥1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pmem_read`  in  1  line read request; held until `pmem_resp`.
- `pmem_write`  in  1  line write request; held until `pmem_resp`.
- `pmem_address`  in  32  byte address (rv32i_word); bits [4:0] ignored.
- `pmem_wdata`  in  256  write line.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `pmem_rdata`  out  256  read line; valid in the `pmem_resp` cycle.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if `pmem_read | pmem_write` at a rising edge, the block latches the op, the index `pmem_address[5+IDX_W-1:5]`, and `pmem_wdata`. It loads `cnt = LATENCY-1` and moves to RESP if `cnt==0`, otherwise to BUSY.
- BUSY: `cnt` decrements each edge; at `cnt==1` the next state is RESP.
- RESP: `pmem_resp=1`. On the edge leaving RESP:
  - a write commits the latched `wdata` to the latched index;
  - the next state is IDLE.
- Read data: `pmem_rdata` is loaded from the array on entry to RESP. It holds its value until the next read enters RESP. Writes do not change `pmem_rdata`.
- Both `pmem_read` and `pmem_write` high: treated as a write; the read is dropped.
- Address bits above `5+IDX_W` are ignored, so addresses alias modulo `DEPTH*32` bytes.
- Inputs during BUSY/RESP are ignored; only the latched copy is used.
- Exactly one response is produced per accepted request. There is no queueing.

## Timing
- The request is first visible in cycle 0 and accepted at the end of cycle 0. `pmem_resp` is high in cycle `LATENCY` only.
- The initiator drops or changes its request in the cycle after `pmem_resp`. The responder is back in IDLE in that cycle, so back-to-back requests see `LATENCY+1` cycles per transaction.
- A write is visible to a read accepted in any cycle after its `pmem_resp` cycle.
- Reset values:
  - state IDLE;
  - `cnt` 0;
  - `pmem_resp` 0;
  - `pmem_rdata` 0;
  - all array lines 0;
  - stats counters 0.
- Reset asserted mid-transaction: the transaction is aborted immediately. There is no commit and no `pmem_resp`. After reset release, the initiator must re-issue the request.

## Configuration
- `PMEM_RESPONDER_STATS_EN` defined:
  - adds outputs `read_count` (out, 16) and `write_count` (out, 16);
  - each increments on the edge leaving RESP for its op type;
  - both saturate at 16'hFFFF;
  - both are cleared by `rst`.
- Not defined: the ports and counters are absent, and the rest of the behaviour is identical.

## Test plan
- Reset, then read address 0x0000_0040 with `LATENCY=4` -> `pmem_resp` high only in cycle 4, `pmem_rdata`=0.
- Write 0xA5…A5 (256-bit) to 0x0000_0020, then read 0x0000_003F -> the read returns 0xA5…A5 (same line, offset ignored).
- `DEPTH=16`: write line X to 0x0000_0000, read 0x0000_0200 -> returns X (alias).
- `pmem_read` and `pmem_write` both high with data Y at line 3 -> single `pmem_resp`; a later read of line 3 returns Y; `pmem_rdata` is unchanged during the write response.
- Assert `rst` in cycle 2 of a write to line 5 -> no `pmem_resp`; after release, a read of line 5 returns 0.
- With `PMEM_RESPONDER_STATS_EN`: 3 reads and 2 writes back-to-back -> `read_count`=3, `write_count`=2, and each response is spaced `LATENCY+1` cycles apart.

Source files
------------

// File: rtl/pmem_responder.sv
// Line-granular memory responder: answers 256-bit line reads/writes after LATENCY cycles.
// Define PMEM_RESPONDER_STATS_EN to add saturating read/write completion counters.
module pmem_responder #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [255:0] pmem_rdata
`ifdef PMEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_write_q, op_write_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [255:0]       wdata_q, wdata_d;
    logic               load_rdata;
    logic               commit;
    logic [255:0]       mem [DEPTH];

    // Offset and alias bits of the address are deliberately not decoded.
    logic unused_addr;
    assign unused_addr = ^{pmem_address[31:5+IDX_W], pmem_address[4:0]};

    assign pmem_resp = (state_q == StResp);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        load_rdata = 1'b0;
        commit     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pmem_read || pmem_write) begin
                    op_write_d = pmem_write;
                    idx_d      = pmem_address[5+IDX_W-1:5];
                    wdata_d    = pmem_wdata;
                    cnt_d      = CNT_INIT;
                    if (CNT_INIT == '0) begin
                        state_d    = StResp;
                        load_rdata = !pmem_write;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = StResp;
                    load_rdata = !op_write_q;
                end
            end
            StResp: begin
                state_d = StIdle;
                commit  = op_write_q;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            pmem_rdata <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            if (load_rdata) begin
                pmem_rdata <= mem[idx_d];
            end
            if (commit) begin
                mem[idx_q] <= wdata_q;
            end
        end
    end

`ifdef PMEM_RESPONDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_count  <= '0;
            write_count <= '0;
        end else if (state_q == StResp) begin
            if (op_write_q) begin
                if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
            end else begin
                if (read_count != 16'hFFFF) read_count <= read_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed self-checking bench for pmem_responder (DEPTH=16, LATENCY=4).
module tb_pmem_responder;

    logic         clk;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
`ifdef PMEM_RESPONDER_STATS_EN
    logic [15:0]  read_count;
    logic [15:0]  write_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    pmem_responder #(
        .DEPTH   (16),
        .LATENCY (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
`ifdef PMEM_RESPONDER_STATS_EN
        ,
        .read_count   (read_count),
        .write_count  (write_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Called just after a rising edge; returns one cycle after the response, request dropped.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wd, output int lat,
                          output logic [255:0] rdata_at_resp, output int resp_cyc);
        pmem_read = rd;
        pmem_write = wr;
        pmem_address = addr;
        pmem_wdata = wd;
        lat = -1;
        rdata_at_resp = '0;
        resp_cyc = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (pmem_resp) begin
                lat = k;
                rdata_at_resp = pmem_rdata;
                resp_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        pmem_read = 1'b0;
        pmem_write = 1'b0;
    endtask

    logic [255:0] pat_a5, pat_x, pat_y, pat_z, pat_w1, pat_w2, rdv;
    int lat, rc, prev_rc, resp_seen;

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_x  = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                  32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
        pat_y  = {8{32'hCAFE_F00D}};
        pat_z  = {8{32'hDEAD_BEEF}};
        pat_w1 = {8{32'h0BAD_1DEA}};
        pat_w2 = {4{64'h0123_4567_89AB_CDEF}};
        pmem_address = '0;
        pmem_wdata = '0;
        do_reset();

        check("reset_resp", {255'd0, pmem_resp}, 256'd0);
        check("reset_rdata", pmem_rdata, 256'd0);

        // Read of never-written line: resp in cycle 4 only, data zero.
        do_req(1'b1, 1'b0, 32'h0000_0040, '0, lat, rdv, rc);
        check("rd0_latency", 256'(lat), 256'd4);
        check("rd0_data", rdv, 256'd0);
        @(negedge clk);
        check("rd0_resp_single", {255'd0, pmem_resp}, 256'd0);
        @(posedge clk);
        #1;

        // Write line 1, read back with non-zero offset.
        do_req(1'b0, 1'b1, 32'h0000_0020, pat_a5, lat, rdv, rc);
        check("wr_a5_latency", 256'(lat), 256'd4);
        check("wr_a5_rdata_held", rdv, 256'd0);
        do_req(1'b1, 1'b0, 32'h0000_003F, '0, lat, rdv, rc);
        check("rd_a5_data", rdv, pat_a5);

        // Aliasing modulo DEPTH*32 bytes.
        do_req(1'b0, 1'b1, 32'h0000_0000, pat_x, lat, rdv, rc);
        do_req(1'b1, 1'b0, 32'h0000_0200, '0, lat, rdv, rc);
        check("alias_data", rdv, pat_x);

        // Read+write together behaves as a write; rdata keeps the last read value.
        do_req(1'b1, 1'b1, 32'h0000_0060, pat_y, lat, rdv, rc);
        check("both_latency", 256'(lat), 256'd4);
        check("both_rdata_held", rdv, pat_x);
        resp_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pmem_resp) resp_seen++;
        end
        check("both_single_resp", 256'(resp_seen), 256'd0);
        @(posedge clk);
        #1;
        do_req(1'b1, 1'b0, 32'h0000_0060, '0, lat, rdv, rc);
        check("both_rd_data", rdv, pat_y);
        do_req(1'b1, 1'b0, 32'h0000_0020, '0, lat, rdv, rc);
        check("line1_intact", rdv, pat_a5);

        // Reset in cycle 2 of a write aborts it with no response.
        pmem_read = 1'b0;
        pmem_write = 1'b1;
        pmem_address = 32'h0000_00A0;
        pmem_wdata = pat_z;
        resp_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                rst = 1'b1;
                pmem_write = 1'b0;
            end
            if (k == 4) rst = 1'b0;
            @(negedge clk);
            if (pmem_resp) resp_seen++;
            @(posedge clk);
            #1;
        end
        check("abort_no_resp", 256'(resp_seen), 256'd0);
        check("abort_rdata_cleared", pmem_rdata, 256'd0);
        do_req(1'b1, 1'b0, 32'h0000_00A0, '0, lat, rdv, rc);
        check("abort_line5_zero", rdv, 256'd0);
        check("abort_rd_latency", 256'(lat), 256'd4);
        do_req(1'b1, 1'b0, 32'h0000_0060, '0, lat, rdv, rc);
        check("array_reset_line3", rdv, 256'd0);

        // Back-to-back traffic: 2 writes, 3 reads, LATENCY+1 cycles apart.
        do_reset();
`ifdef PMEM_RESPONDER_STATS_EN
        check("stats_rd_reset", 256'(read_count), 256'd0);
        check("stats_wr_reset", 256'(write_count), 256'd0);
`endif
        do_req(1'b0, 1'b1, 32'h0000_00E0, pat_w1, lat, rdv, prev_rc);
        do_req(1'b1, 1'b0, 32'h0000_00E0, '0, lat, rdv, rc);
        check("b2b_rd7", rdv, pat_w1);
        check("b2b_gap1", 256'(rc - prev_rc), 256'd5);
        prev_rc = rc;
        do_req(1'b0, 1'b1, 32'h0000_0100, pat_w2, lat, rdv, rc);
        check("b2b_wr_rdata_held", rdv, pat_w1);
        check("b2b_gap2", 256'(rc - prev_rc), 256'd5);
        prev_rc = rc;
        do_req(1'b1, 1'b0, 32'h0000_0100, '0, lat, rdv, rc);
        check("b2b_rd8", rdv, pat_w2);
        check("b2b_gap3", 256'(rc - prev_rc), 256'd5);
        prev_rc = rc;
        do_req(1'b1, 1'b0, 32'h0000_00E0, '0, lat, rdv, rc);
        check("b2b_rd7_again", rdv, pat_w1);
        check("b2b_gap4", 256'(rc - prev_rc), 256'd5);
`ifdef PMEM_RESPONDER_STATS_EN
        check("stats_reads", 256'(read_count), 256'd3);
        check("stats_writes", 256'(write_count), 256'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
